mem_arbiter: RTL

Two-to-one memory arbiter sitting directly downstream of the pipelined `cpu`, consuming its separate instruction (`imem_*`) and data (`dmem_*`) request ports and multiplexing them onto one shared memory port (`mem_*`) toward the cache/memory hierarchy. It grants one request at a time, registers the granted request toward memory and holds it until `mem_resp`. It then routes the response back to the requesting side as a single-cycle `imem_resp` or `dmem_resp`.

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter merging the CPU instruction and data ports onto one
// registered memory port; responses are routed back combinationally.
module mem_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic [31:0] imem_address,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_resp,
  output logic [31:0] dmem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_I_BUSY = 2'd1;
  localparam logic [1:0] S_D_BUSY = 2'd2;

  logic [1:0]  r_state;
  logic        r_last_d;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wdata;

  logic w_d_pend;
  logic w_i_pend;
  logic w_grant_d;
  logic w_grant_i;

  // I only beats a pending D on a tie when round-robin says D went last.
  always_comb begin
    w_d_pend  = dmem_read | dmem_write;
    w_i_pend  = imem_read;
    w_grant_d = w_d_pend & ~(w_i_pend & RR_ENABLE & r_last_d);
    w_grant_i = w_i_pend & ~w_grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_last_d      <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wmask   <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state       <= S_D_BUSY;
            r_last_d      <= 1'b1;
            r_mem_read    <= ~dmem_write;
            r_mem_write   <= dmem_write;
            r_mem_wmask   <= dmem_write ? dmem_wmask : '0;
            r_mem_wdata   <= dmem_write ? dmem_wdata : '0;
            r_mem_address <= dmem_address;
          end else if (w_grant_i) begin
            r_state       <= S_I_BUSY;
            r_last_d      <= 1'b0;
            r_mem_read    <= 1'b1;
            r_mem_write   <= 1'b0;
            r_mem_wmask   <= '0;
            r_mem_wdata   <= '0;
            r_mem_address <= imem_address;
          end
        end
        S_I_BUSY, S_D_BUSY: begin
          if (mem_resp) begin
            r_state     <= S_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wmask   = r_mem_wmask;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  assign imem_resp  = (r_state == S_I_BUSY) & mem_resp;
  assign dmem_resp  = (r_state == S_D_BUSY) & mem_resp;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule
